alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; also the MUL/DIV iteration count.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous reset, active-high.
REQ-004 start  input  1  request strobe; accepted only when busy==0.
REQ-005 alucontrol  input  4  operation code from the ALU decoder.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 result  output  WIDTH  registered result; held until the next valid.
REQ-009 zero  output  1  registered; 1 when result==0.
REQ-010 valid  output  1  one-cycle pulse; result/zero/illegal are fresh.
REQ-011 busy  output  1  high while a MUL/DIV iteration is in progress.
REQ-012 illegal  output  1  registered; set with valid for an unsupported alucontrol.

Function
REQ-013 Codes: 0010 add, 1010 sub, 0000 and, 0001 or, 1011 slt (signed, result 0 or 1), 0100 mul, 0101 div; all other codes are illegal.
REQ-014 States: IDLE, MUL, DIV, DONE; a, b and alucontrol are latched on the accepting edge.
REQ-015 Accept on edge N: single-cycle op -> DONE, valid=1 in cycle N+1.
REQ-016 Accept on edge N: MUL or DIV -> busy=1 for exactly WIDTH cycles, then DONE; valid=1 in cycle N+WIDTH+1.
REQ-017 DONE lasts one cycle -> IDLE, unless start is accepted in DONE, which follows REQ-015/016.
REQ-018 start while busy==1 is ignored: no latch, no effect on the running op.
REQ-019 add/sub wrap modulo 2^WIDTH; no carry or overflow outputs.
REQ-020 mul: iterative shift-add, one bit per cycle; result is the low WIDTH bits of the product.
REQ-021 div: signed quotient, truncated toward zero; restoring divide on magnitudes with sign fix-up; one bit per cycle.
REQ-022 div by zero: result all-ones; latency still WIDTH+1.
REQ-023 div of most-negative by -1: result most-negative; latency still WIDTH+1.
REQ-024 Illegal code: result 0, illegal=1, zero=1, latency 1.
REQ-025 illegal is cleared by any valid for a legal op.
REQ-026 Outside valid cycles, result/zero/illegal hold their last values.

Reset
REQ-027 reset=1 at a rising edge: state IDLE, result 0, zero 1, valid 0, busy 0, illegal 0, iteration counter 0.
REQ-028 Reset mid-MUL/DIV aborts the op: no valid is produced for it.
REQ-029 The first start is accepted on the first edge with reset=0.
REQ-030 reset has priority over a simultaneous start.

Configuration
REQ-031 Macro ALU_MULDIV_EN defined: mul/div implemented per REQ-016, 020-023.
REQ-032 Macro ALU_MULDIV_EN undefined: no multiplier/divider logic; 0100/0101 handled as illegal per REQ-024; busy is constant 0.

Verification
REQ-033 add a=5, b=7 -> result 12, zero 0, valid exactly 1 cycle after accept; then sub 7-7 -> 0, zero 1; slt a=0xFFFFFFFF, b=1 -> 1.
REQ-034 mul a=0xFFFFFFFF, b=3 -> 0xFFFFFFFD, valid 33 cycles after accept, busy high 32 cycles; start with add pulsed mid-op is ignored.
REQ-035 div -7/2 -> 0xFFFFFFFD; 5/0 -> 0xFFFFFFFF; 0x80000000/0xFFFFFFFF -> 0x80000000; each with latency 33.
REQ-036 alucontrol=0011 -> result 0, illegal 1, zero 1 at latency 1; the next legal add clears illegal.
REQ-037 Build without ALU_MULDIV_EN: alucontrol=0100 -> illegal 1, latency 1, busy never asserted.
REQ-038 reset pulsed 10 cycles into a div -> no valid, busy 0 next cycle; a following add 1+1 -> 2 at latency 1.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with registered result/zero/illegal and a one-cycle valid pulse.
// Define ALU_MULDIV_EN to build the iterative multiplier/divider; otherwise 0100/0101 are illegal.
module alu_mc #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       alucontrol,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             valid,
   output logic             busy,
   output logic             illegal
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b1010;
   localparam logic [3:0] OP_SLT = 4'b1011;
`ifdef ALU_MULDIV_EN
   localparam logic [3:0] OP_MUL = 4'b0100;
   localparam logic [3:0] OP_DIV = 4'b0101;
   localparam int         CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_DONE
   } state_t;

   state_t           state;
   state_t           state_next;
   logic             accept;
   logic [3:0]       op_code;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] alu_out;
   logic             alu_illegal;

`ifdef ALU_MULDIV_EN
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] rem;
   logic [WIDTH:0]   trial;
   logic             neg;
   logic             dz;

   assign busy  = (state == S_MUL) || (state == S_DIV);
   assign trial = {rem, op_a[WIDTH-1]};
`else
   assign busy = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      accept     = start && ((state == S_IDLE) || (state == S_DONE));
      state_next = state;
      case (state)
         S_IDLE, S_DONE: begin
            state_next = S_IDLE;
            if (accept) begin
               state_next = S_DONE;
`ifdef ALU_MULDIV_EN
               if (alucontrol == OP_MUL) begin
                  state_next = S_MUL;
               end else if (alucontrol == OP_DIV) begin
                  state_next = S_DIV;
               end
`endif
            end
         end
`ifdef ALU_MULDIV_EN
         S_MUL, S_DIV: begin
            if (cnt == LAST) begin
               state_next = S_DONE;
            end
         end
`endif
         default: state_next = S_IDLE;
      endcase
   end

   // Final value for the latched op; evaluated in DONE from the operand/iteration registers.
   always_comb begin
      alu_out     = '0;
      alu_illegal = 1'b0;
      case (op_code)
         OP_ADD: alu_out = op_a + op_b;
         OP_SUB: alu_out = op_a - op_b;
         OP_AND: alu_out = op_a & op_b;
         OP_OR:  alu_out = op_a | op_b;
         OP_SLT: alu_out = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
`ifdef ALU_MULDIV_EN
         OP_MUL: alu_out = acc;
         OP_DIV: begin
            if (dz) begin
               alu_out = '1;
            end else if (neg) begin
               alu_out = '0 - op_a;
            end else begin
               alu_out = op_a;
            end
         end
`endif
         default: alu_illegal = 1'b1;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         result  <= '0;
         zero    <= 1'b1;
         valid   <= 1'b0;
         illegal <= 1'b0;
`ifdef ALU_MULDIV_EN
         cnt     <= '0;
`endif
      end else begin
         valid <= 1'b0;
         if (state == S_DONE) begin
            result  <= alu_out;
            zero    <= (alu_out == '0);
            illegal <= alu_illegal;
            valid   <= 1'b1;
         end
         if (accept) begin
            op_code <= alucontrol;
            op_a    <= a;
            op_b    <= b;
`ifdef ALU_MULDIV_EN
            cnt     <= '0;
            acc     <= '0;
            rem     <= '0;
            neg     <= a[WIDTH-1] ^ b[WIDTH-1];
            dz      <= (b == '0);
            // Divide runs on magnitudes; the quotient sign is restored in DONE.
            if (alucontrol == OP_DIV) begin
               op_a <= a[WIDTH-1] ? ('0 - a) : a;
               op_b <= b[WIDTH-1] ? ('0 - b) : b;
            end
`endif
         end
`ifdef ALU_MULDIV_EN
         if (busy) begin
            cnt <= cnt + 1'b1;
            if (state == S_MUL) begin
               if (op_b[0]) begin
                  acc <= acc + op_a;
               end
               op_a <= op_a << 1;
               op_b <= op_b >> 1;
            end else if (trial >= {1'b0, op_b}) begin
               rem  <= WIDTH'(trial - {1'b0, op_b});
               op_a <= {op_a[WIDTH-2:0], 1'b1};
            end else begin
               rem  <= trial[WIDTH-1:0];
               op_a <= {op_a[WIDTH-2:0], 1'b0};
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed corner cases plus random ops against a reference model.
// Follows the DUT build: define ALU_MULDIV_EN for both to exercise mul/div.
module tb_alu_mc;

   logic        clock;
   logic        reset;
   logic        start;
   logic [3:0]  alucontrol;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] result;
   logic        zero;
   logic        valid;
   logic        busy;
   logic        illegal;

   int n_checks = 0;
   int n_err    = 0;

   alu_mc #(.WIDTH(32)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .alucontrol (alucontrol),
      .a          (a),
      .b          (b),
      .result     (result),
      .zero       (zero),
      .valid      (valid),
      .busy       (busy),
      .illegal    (illegal)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference behaviour from the operation table, using plain arithmetic.
   function automatic void ref_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic ill, output int lat);
      logic [63:0] p;
      int sx;
      int sy;
      sx  = x;
      sy  = y;
      r   = 32'd0;
      ill = 1'b0;
      lat = 1;
      p   = 64'd0;
      case (op)
         4'b0010: r = x + y;
         4'b1010: r = x - y;
         4'b0000: r = x & y;
         4'b0001: r = x | y;
         4'b1011: r = (sx < sy) ? 32'd1 : 32'd0;
`ifdef ALU_MULDIV_EN
         4'b0100: begin
            p   = {32'd0, x} * {32'd0, y};
            r   = p[31:0];
            lat = 33;
         end
         4'b0101: begin
            lat = 33;
            if (y == 32'd0) r = 32'hFFFF_FFFF;
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h8000_0000;
            else r = sx / sy;
         end
`endif
         default: ill = 1'b1;
      endcase
   endfunction

   task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         input bit pulse_mid, input string tag);
      logic [31:0] er;
      logic        eill;
      int          elat;
      int          lat;
      int          bcnt;
      ref_op(op, x, y, er, eill, elat);
      @(negedge clock);
      reset = 1'b0;
      start = 1'b1;
      alucontrol = op;
      a = x;
      b = y;
      @(posedge clock);
      #1;
      start = 1'b0;
      alucontrol = 4'($urandom);
      a = $urandom;
      b = $urandom;
      lat  = 0;
      bcnt = 0;
      while (lat < 200 && !valid) begin
         if (busy) bcnt++;
         start = pulse_mid && (lat == 10);
         if (start) alucontrol = 4'b0010;
         @(posedge clock);
         #1;
         lat++;
      end
      start = 1'b0;
      check({tag, " latency"}, lat, elat);
      check({tag, " result"}, result, er);
      check({tag, " zero"}, {31'd0, zero}, {31'd0, (er == 32'd0)});
      check({tag, " illegal"}, {31'd0, illegal}, {31'd0, eill});
      check({tag, " busy cycles"}, bcnt, elat - 1);
      @(posedge clock);
      #1;
      check({tag, " valid pulse"}, {31'd0, valid}, 32'd0);
      check({tag, " hold"}, result, er);
   endtask

   initial begin
      logic [3:0]  codes [8];
      logic [3:0]  op;
      logic [31:0] x;
      logic [31:0] y;
      int          nvalid;

      codes = '{4'b0010, 4'b1010, 4'b0000, 4'b0001, 4'b1011, 4'b0100, 4'b0101, 4'b0011};
      reset = 1'b1;
      start = 1'b0;
      alucontrol = 4'b0000;
      a = 32'd0;
      b = 32'd0;
      repeat (3) @(posedge clock);
      #1;
      check("reset result", result, 32'd0);
      check("reset zero", {31'd0, zero}, 32'd1);
      check("reset valid", {31'd0, valid}, 32'd0);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset illegal", {31'd0, illegal}, 32'd0);

      // reset wins over a simultaneous start
      @(negedge clock);
      start = 1'b1;
      alucontrol = 4'b0010;
      a = 32'd1;
      b = 32'd2;
      @(posedge clock);
      #1;
      start = 1'b0;
      check("rst+start busy", {31'd0, busy}, 32'd0);
      @(posedge clock);
      #1;
      check("rst+start valid", {31'd0, valid}, 32'd0);

      run_op(4'b0010, 32'd5, 32'd7, 1'b0, "add 5+7");
      run_op(4'b1010, 32'd7, 32'd7, 1'b0, "sub 7-7");
      run_op(4'b1011, 32'hFFFF_FFFF, 32'd1, 1'b0, "slt -1<1");
      run_op(4'b0100, 32'hFFFF_FFFF, 32'd3, 1'b1, "mul");
      run_op(4'b0101, 32'hFFFF_FFF9, 32'd2, 1'b0, "div -7/2");
      run_op(4'b0101, 32'd5, 32'd0, 1'b0, "div 5/0");
      run_op(4'b0101, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div minneg");
      run_op(4'b0011, 32'd9, 32'd9, 1'b0, "illegal 0011");
      run_op(4'b0010, 32'd1, 32'd0, 1'b0, "add clears illegal");
      run_op(4'b0100, 32'd6, 32'd7, 1'b0, "code 0100");

      // start accepted while in DONE
      @(negedge clock);
      start = 1'b1;
      alucontrol = 4'b0010;
      a = 32'd3;
      b = 32'd4;
      @(posedge clock);
      #1;
      alucontrol = 4'b1010;
      a = 32'd10;
      b = 32'd4;
      @(posedge clock);
      #1;
      start = 1'b0;
      check("b2b first valid", {31'd0, valid}, 32'd1);
      check("b2b first result", result, 32'd7);
      @(posedge clock);
      #1;
      check("b2b second valid", {31'd0, valid}, 32'd1);
      check("b2b second result", result, 32'd6);
      @(posedge clock);
      #1;
      check("b2b idle", {31'd0, valid}, 32'd0);

`ifdef ALU_MULDIV_EN
      // reset aborts a running divide
      @(negedge clock);
      start = 1'b1;
      alucontrol = 4'b0101;
      a = 32'd100;
      b = 32'd3;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clock);
      #1;
      check("div running busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      check("abort busy", {31'd0, busy}, 32'd0);
      check("abort valid", {31'd0, valid}, 32'd0);
      nvalid = 0;
      repeat (40) begin
         @(posedge clock);
         #1;
         if (valid) nvalid++;
      end
      check("abort no valid", nvalid, 0);
      run_op(4'b0010, 32'd1, 32'd1, 1'b0, "add after abort");
`endif

      for (int i = 0; i < 40; i++) begin
         op = codes[$urandom_range(0, 7)];
         if (op == 4'b0011) op = 4'($urandom);
         case ($urandom_range(0, 5))
            0: x = 32'd0;
            1: x = 32'h8000_0000;
            2: x = 32'hFFFF_FFFF;
            default: x = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0: y = 32'd0;
            1: y = 32'hFFFF_FFFF;
            2: y = 32'($urandom_range(1, 9));
            default: y = $urandom;
         endcase
         run_op(op, x, y, ($urandom_range(0, 3) == 0), "random");
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
